sensor_emu_frame_seq: RTL and testbench

- Frame sequencer that sits between the sensor-emulator pattern streamer and the downstream frame consumer.
- Commands the streamer which pattern FIFO to play and when. Slices the streamer's continuous pattern stream into frames of a programmed beat count, each ending with TLAST, separated by programmed idle gaps.
- Supports single-FIFO or alternating-FIFO-per-frame schedules, a fixed frame count or continuous run, graceful stop and abort.

---
 rtl/sensor_emu_pkg.sv | 23 ++
 rtl/sensor_emu_frame_gate.sv | 45 ++++
 rtl/sensor_emu_frame_seq.sv | 196 +++++++++++++++++++
 tb/tb_sensor_emu_frame_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_emu_pkg.sv
// Shared types and constants for the sensor-emulator frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sensor_emu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM_STOP  = 3'd1,
        ARM_START = 3'd2,
        ARM_WAIT  = 3'd3,
        FRAME     = 3'd4,
        GAP       = 3'd5,
        HALT      = 3'd6
    } seq_state_t;

    localparam logic [1:0] SEL_F0  = 2'd1;
    localparam logic [1:0] SEL_F1  = 2'd2;
    localparam logic [1:0] SEL_ALT = 2'd3;

    localparam int ERR_CFG = 0;
    localparam int ERR_TMO = 1;

endpackage

// File: rtl/sensor_emu_frame_gate.sv
// Gates the pattern stream into frames: pass-through enable, beat counter, TLAST.
// Latency: zero-cycle combinational pass-through of data/valid/ready.
// Backpressure: sink ready flows straight back to the streamer; stalled when not enabled.
module sensor_emu_frame_gate #(
    parameter int PATTERN_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic [31:0]              frame_len,
    input  logic [PATTERN_WIDTH-1:0] in_tdata,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    output logic [PATTERN_WIDTH-1:0] out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     out_tlast,
    output logic                     beat,
    output logic                     last_beat
);

    logic [31:0] beat_cnt;

    // Pass-through gated by the FRAME enable; TLAST on the final beat position.
    always_comb begin
        out_tvalid = en & in_tvalid;
        in_tready  = en & out_tready;
        out_tdata  = in_tdata;
        out_tlast  = en & (beat_cnt == frame_len - 32'd1);
        beat       = out_tvalid & out_tready;
        last_beat  = beat & out_tlast;
    end

    // Beat counter: held at zero outside FRAME so every frame starts at beat 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_cnt <= '0;
        end else if (!en || last_beat) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/sensor_emu_frame_seq.sv
// Frame sequencer: arms the pattern streamer and slices its stream into gapped frames.
// Latency: first beat 4 cycles after RUN (ARM_STOP, ARM_START, ARM_WAIT, FRAME).
// Backpressure: AXIS ready passes straight through during FRAME; streamer stalled otherwise.
module sensor_emu_frame_seq
    import sensor_emu_pkg::*;
#(
    parameter int PATTERN_WIDTH = 32,
    parameter int ARM_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              i_FRAME_LEN,
    input  logic [31:0]              i_GAP_CYCLES,
    input  logic [31:0]              i_FRAME_COUNT,
    input  logic [1:0]               i_FIFO_SEL,
    input  logic                     i_RUN_wstrobe,
    input  logic                     i_STOP_wstrobe,
    input  logic                     i_ABORT_wstrobe,
    output logic [1:0]               o_START,
    output logic                     o_START_wstrobe,
    output logic                     o_HARD_STOP_wstrobe,
    input  logic [1:0]               i_ACTIVE_FIFO,
    input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic                     AXIS_IN_TVALID,
    output logic                     AXIS_IN_TREADY,
    output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                     AXIS_OUT_TVALID,
    input  logic                     AXIS_OUT_TREADY,
    output logic                     AXIS_OUT_TLAST,
    output logic                     o_BUSY,
    output logic [31:0]              o_FRAMES_SENT,
    output logic [1:0]               o_ERROR
);

    seq_state_t  state, state_nxt;
    logic [1:0]  target, target_nxt;
    logic        alt, alt_nxt;
    logic [31:0] len, len_nxt, gap, gap_nxt, count, count_nxt;
    logic [31:0] frames, frames_nxt, gap_cnt, gap_cnt_nxt, tmo_cnt, tmo_cnt_nxt;
    logic [1:0]  err, err_nxt;
    logic        stop_pend, stop_pend_nxt;
    logic        beat, last_beat;

    sensor_emu_frame_gate #(.PATTERN_WIDTH(PATTERN_WIDTH)) u_gate (
        .clk        (clk),
        .resetn     (resetn),
        .en         (state == FRAME),
        .frame_len  (len),
        .in_tdata   (AXIS_IN_TDATA),
        .in_tvalid  (AXIS_IN_TVALID),
        .in_tready  (AXIS_IN_TREADY),
        .out_tdata  (AXIS_OUT_TDATA),
        .out_tvalid (AXIS_OUT_TVALID),
        .out_tready (AXIS_OUT_TREADY),
        .out_tlast  (AXIS_OUT_TLAST),
        .beat       (beat),
        .last_beat  (last_beat)
    );

    assign o_BUSY        = (state != IDLE);
    assign o_FRAMES_SENT = frames;
    assign o_ERROR       = err;

    // Next-state, register updates and streamer command strobes.
    always_comb begin
        state_nxt           = state;
        target_nxt          = target;
        alt_nxt             = alt;
        len_nxt             = len;
        gap_nxt             = gap;
        count_nxt           = count;
        frames_nxt          = frames;
        gap_cnt_nxt         = gap_cnt;
        tmo_cnt_nxt         = tmo_cnt;
        err_nxt             = err;
        stop_pend_nxt       = stop_pend;
        o_START             = 2'd0;
        o_START_wstrobe     = 1'b0;
        o_HARD_STOP_wstrobe = 1'b0;

        case (state)
            IDLE: begin
                if (i_RUN_wstrobe) begin
                    len_nxt    = i_FRAME_LEN;
                    gap_nxt    = i_GAP_CYCLES;
                    count_nxt  = i_FRAME_COUNT;
                    alt_nxt    = (i_FIFO_SEL == SEL_ALT);
                    frames_nxt = '0;
                    err_nxt    = '0;
                    if (i_FRAME_LEN == 32'd0 || i_FIFO_SEL == 2'd0) begin
                        err_nxt[ERR_CFG] = 1'b1;
                    end else begin
                        target_nxt = (i_FIFO_SEL == SEL_F1) ? SEL_F1 : SEL_F0;
                        state_nxt  = ARM_STOP;
                    end
                end
            end
            ARM_STOP: begin
                o_HARD_STOP_wstrobe = 1'b1;
                state_nxt           = ARM_START;
            end
            ARM_START: begin
                o_START         = target;
                o_START_wstrobe = 1'b1;
                tmo_cnt_nxt     = '0;
                state_nxt       = ARM_WAIT;
            end
            ARM_WAIT: begin
                if (i_ACTIVE_FIFO == target) begin
                    state_nxt = FRAME;
                end else if (tmo_cnt + 32'd1 == 32'(ARM_TIMEOUT)) begin
                    err_nxt[ERR_TMO] = 1'b1;
                    state_nxt        = HALT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 32'd1;
                end
            end
            FRAME: begin
                if (last_beat) begin
                    frames_nxt = frames + 32'd1;
                    if (stop_pend || i_STOP_wstrobe ||
                        (count != 32'd0 && frames + 32'd1 == count)) begin
                        state_nxt = HALT;
                    end else begin
                        if (alt) begin
                            target_nxt = (target == SEL_F0) ? SEL_F1 : SEL_F0;
                        end
                        if (gap != 32'd0) begin
                            gap_cnt_nxt = '0;
                            state_nxt   = GAP;
                        end else if (alt) begin
                            state_nxt = ARM_STOP;
                        end
                    end
                end else if (i_STOP_wstrobe) begin
                    stop_pend_nxt = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == gap - 32'd1) begin
                    state_nxt = alt ? ARM_STOP : FRAME;
                end else begin
                    gap_cnt_nxt = gap_cnt + 32'd1;
                end
            end
            HALT: begin
                o_START             = 2'd0;
                o_START_wstrobe     = 1'b1;
                o_HARD_STOP_wstrobe = 1'b1;
                stop_pend_nxt       = 1'b0;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort always wins; stop outside FRAME halts without starting another frame.
        if (state != IDLE && state != HALT) begin
            if (i_ABORT_wstrobe) begin
                state_nxt = HALT;
            end else if (i_STOP_wstrobe && state != FRAME) begin
                stop_pend_nxt = 1'b1;
                state_nxt     = HALT;
            end
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            target    <= 2'd0;
            alt       <= 1'b0;
            len       <= '0;
            gap       <= '0;
            count     <= '0;
            frames    <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            err       <= '0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            alt       <= alt_nxt;
            len       <= len_nxt;
            gap       <= gap_nxt;
            count     <= count_nxt;
            frames    <= frames_nxt;
            gap_cnt   <= gap_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            err       <= err_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

endmodule

// File: tb/tb_sensor_emu_frame_seq.sv
// Directed bench for the frame sequencer with a simple two-FIFO streamer stand-in.
// Latency: checks first-beat, inter-frame and halt timing in cycles.
// Backpressure: optional random sink ready.
module tb_sensor_emu_frame_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] i_FRAME_LEN, i_GAP_CYCLES, i_FRAME_COUNT;
    logic [1:0]  i_FIFO_SEL;
    logic        i_RUN_wstrobe, i_STOP_wstrobe, i_ABORT_wstrobe;
    logic [1:0]  o_START;
    logic        o_START_wstrobe, o_HARD_STOP_wstrobe;
    logic [1:0]  i_ACTIVE_FIFO;
    logic [31:0] AXIS_IN_TDATA, AXIS_OUT_TDATA;
    logic        AXIS_IN_TVALID, AXIS_IN_TREADY;
    logic        AXIS_OUT_TVALID, AXIS_OUT_TREADY, AXIS_OUT_TLAST;
    logic        o_BUSY;
    logic [31:0] o_FRAMES_SENT;
    logic [1:0]  o_ERROR;

    always #5 clk = ~clk;

    sensor_emu_frame_seq #(.PATTERN_WIDTH(32), .ARM_TIMEOUT(255)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .i_FRAME_LEN         (i_FRAME_LEN),
        .i_GAP_CYCLES        (i_GAP_CYCLES),
        .i_FRAME_COUNT       (i_FRAME_COUNT),
        .i_FIFO_SEL          (i_FIFO_SEL),
        .i_RUN_wstrobe       (i_RUN_wstrobe),
        .i_STOP_wstrobe      (i_STOP_wstrobe),
        .i_ABORT_wstrobe     (i_ABORT_wstrobe),
        .o_START             (o_START),
        .o_START_wstrobe     (o_START_wstrobe),
        .o_HARD_STOP_wstrobe (o_HARD_STOP_wstrobe),
        .i_ACTIVE_FIFO       (i_ACTIVE_FIFO),
        .AXIS_IN_TDATA       (AXIS_IN_TDATA),
        .AXIS_IN_TVALID      (AXIS_IN_TVALID),
        .AXIS_IN_TREADY      (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA      (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID     (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY     (AXIS_OUT_TREADY),
        .AXIS_OUT_TLAST      (AXIS_OUT_TLAST),
        .o_BUSY              (o_BUSY),
        .o_FRAMES_SENT       (o_FRAMES_SENT),
        .o_ERROR             (o_ERROR)
    );

    // Streamer stand-in: FIFO0 words 0x1000_0000+n, FIFO1 words 0x2000_0000+n.
    logic        hold_zero;
    logic [1:0]  act;
    logic [31:0] idx0, idx1;
    assign i_ACTIVE_FIFO  = act;
    assign AXIS_IN_TVALID = (act != 2'd0);
    assign AXIS_IN_TDATA  = (act == 2'd2) ? 32'h2000_0000 + idx1 : 32'h1000_0000 + idx0;

    always @(posedge clk) begin
        if (!resetn) begin
            act  <= 2'd0;
            idx0 <= '0;
            idx1 <= '0;
        end else begin
            if (AXIS_IN_TVALID && AXIS_IN_TREADY) begin
                if (act == 2'd2) idx1 <= idx1 + 32'd1;
                else             idx0 <= idx0 + 32'd1;
            end
            if (o_START_wstrobe)          act <= hold_zero ? 2'd0 : o_START;
            else if (o_HARD_STOP_wstrobe) act <= 2'd0;
        end
    end

    // Sink ready: always ready unless random backpressure is enabled.
    logic rand_rdy, rnd_bit;
    assign AXIS_OUT_TREADY = rand_rdy ? rnd_bit : 1'b1;
    initial rnd_bit = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 1) == 1);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: accepted beats and strobe activity.
    logic [31:0] q_dat[$];
    logic        q_lst[$];
    int          q_cyc[$];
    int          n_hs = 0, n_st = 0, n_halt = 0, halt_cyc = -1;
    always @(negedge clk) begin
        if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
            q_dat.push_back(AXIS_OUT_TDATA);
            q_lst.push_back(AXIS_OUT_TLAST);
            q_cyc.push_back(cyc);
        end
        if (o_HARD_STOP_wstrobe) n_hs = n_hs + 1;
        if (o_START_wstrobe)     n_st = n_st + 1;
        if (o_HARD_STOP_wstrobe && o_START_wstrobe && o_START == 2'd0) begin
            n_halt   = n_halt + 1;
            halt_cyc = cyc;
        end
    end

    int n_vec = 0, n_bad = 0;
    int run_cyc, ab_cyc, b, hs0, st0, h0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        step(1);
    endtask

    task automatic pulse_run(input logic [31:0] len, input logic [31:0] gp,
                             input logic [31:0] cnt, input logic [1:0] sel);
        b   = q_dat.size();
        hs0 = n_hs;
        st0 = n_st;
        h0  = n_halt;
        i_FRAME_LEN   = len;
        i_GAP_CYCLES  = gp;
        i_FRAME_COUNT = cnt;
        i_FIFO_SEL    = sel;
        i_RUN_wstrobe = 1'b1;
        run_cyc       = cyc;
        step(1);
        i_RUN_wstrobe = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (o_BUSY && k < budget) begin
            step(1);
            k++;
        end
        check_vec(tag, o_BUSY, 1'b0);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (q_dat.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check_vec(tag, q_dat.size(), n);
    endtask

    initial begin
        resetn = 1'b0;
        hold_zero = 1'b0;
        rand_rdy = 1'b0;
        i_FRAME_LEN = '0; i_GAP_CYCLES = '0; i_FRAME_COUNT = '0; i_FIFO_SEL = '0;
        i_RUN_wstrobe = 1'b0; i_STOP_wstrobe = 1'b0; i_ABORT_wstrobe = 1'b0;
        step(2);

        // Reset state
        check_vec("rst_busy",   o_BUSY, 0);
        check_vec("rst_frames", o_FRAMES_SENT, 0);
        check_vec("rst_err",    o_ERROR, 0);
        check_vec("rst_start",  {o_START, o_START_wstrobe, o_HARD_STOP_wstrobe}, 0);
        check_vec("rst_axis",   {AXIS_IN_TREADY, AXIS_OUT_TVALID, AXIS_OUT_TLAST}, 0);
        resetn = 1'b1;
        step(1);

        // 1: LEN=4 GAP=0 COUNT=3 FIFO0, always ready
        do_reset();
        pulse_run(4, 0, 3, 2'd1);
        wait_idle("t1_idle", 100);
        check_vec("t1_beats", q_dat.size() - b, 12);
        for (int i = 0; i < 12; i++) begin
            check_vec($sformatf("t1_dat%0d", i), q_dat[b+i], 32'h1000_0000 + i);
            check_vec($sformatf("t1_lst%0d", i), q_lst[b+i], (i % 4) == 3);
        end
        check_vec("t1_first_cyc", q_cyc[b], run_cyc + 4);
        check_vec("t1_contig",    q_cyc[b+11] - q_cyc[b], 11);
        check_vec("t1_frames",    o_FRAMES_SENT, 3);
        check_vec("t1_halts",     n_halt - h0, 1);
        check_vec("t1_halt_cyc",  halt_cyc, q_cyc[b+11] + 1);

        // 2: LEN=3 GAP=5 COUNT=2 alternate
        do_reset();
        pulse_run(3, 5, 2, 2'd3);
        wait_idle("t2_idle", 200);
        check_vec("t2_beats", q_dat.size() - b, 6);
        for (int i = 0; i < 3; i++) begin
            check_vec($sformatf("t2_f0_%0d", i), q_dat[b+i],   32'h1000_0000 + i);
            check_vec($sformatf("t2_f1_%0d", i), q_dat[b+3+i], 32'h2000_0000 + i);
        end
        check_vec("t2_lst", {q_lst[b], q_lst[b+1], q_lst[b+2], q_lst[b+3], q_lst[b+4], q_lst[b+5]}, 6'b001001);
        check_vec("t2_gap",    q_cyc[b+3] - q_cyc[b+2], 9);
        check_vec("t2_hs",     n_hs - hs0, 3);
        check_vec("t2_st",     n_st - st0, 3);
        check_vec("t2_frames", o_FRAMES_SENT, 2);

        // 3: LEN=8 continuous, random backpressure, STOP in frame 2
        do_reset();
        rand_rdy = 1'b1;
        pulse_run(8, 0, 0, 2'd1);
        wait_beats("t3_pre", b + 11, 600);
        i_STOP_wstrobe = 1'b1;
        step(1);
        i_STOP_wstrobe = 1'b0;
        wait_idle("t3_idle", 600);
        rand_rdy = 1'b0;
        check_vec("t3_beats", q_dat.size() - b, 16);
        for (int i = 0; i < 16; i++) begin
            check_vec($sformatf("t3_dat%0d", i), q_dat[b+i], 32'h1000_0000 + i);
            check_vec($sformatf("t3_lst%0d", i), q_lst[b+i], (i % 8) == 7);
        end
        check_vec("t3_frames", o_FRAMES_SENT, 2);

        // 4: ABORT inside a LEN=6 frame from FIFO1
        do_reset();
        pulse_run(6, 0, 0, 2'd2);
        wait_beats("t4_pre", b + 2, 50);
        i_ABORT_wstrobe = 1'b1;
        ab_cyc = cyc;
        step(1);
        i_ABORT_wstrobe = 1'b0;
        wait_idle("t4_idle", 20);
        check_vec("t4_beats", q_dat.size() - b, 3);
        check_vec("t4_dat2",  q_dat[b+2], 32'h2000_0002);
        check_vec("t4_nolast", {q_lst[b], q_lst[b+1], q_lst[b+2]}, 3'b000);
        check_vec("t4_frames", o_FRAMES_SENT, 0);
        check_vec("t4_halt_cyc", halt_cyc, ab_cyc + 1);

        // 5: illegal configs
        do_reset();
        pulse_run(0, 0, 1, 2'd1);
        step(2);
        check_vec("t5a_err",  o_ERROR, 2'b01);
        check_vec("t5a_busy", o_BUSY, 0);
        check_vec("t5a_strb", (n_hs - hs0) + (n_st - st0), 0);
        pulse_run(4, 0, 1, 2'd0);
        step(2);
        check_vec("t5b_err",  o_ERROR, 2'b01);
        check_vec("t5b_busy", o_BUSY, 0);
        check_vec("t5b_strb", (n_hs - hs0) + (n_st - st0), 0);

        // 6: arm timeout (error from step 5 must be cleared by this RUN)
        hold_zero = 1'b1;
        pulse_run(4, 0, 1, 2'd1);
        wait_idle("t6_idle", 400);
        hold_zero = 1'b0;
        check_vec("t6_err",      o_ERROR, 2'b10);
        check_vec("t6_halt_cyc", halt_cyc, run_cyc + 258);
        check_vec("t6_beats",    q_dat.size() - b, 0);

        // 7: reset mid-frame
        do_reset();
        pulse_run(100, 0, 0, 2'd1);
        wait_beats("t7_pre", b + 5, 50);
        resetn = 1'b0;
        step(1);
        check_vec("t7_busy",  o_BUSY, 0);
        check_vec("t7_axis",  {AXIS_IN_TREADY, AXIS_OUT_TVALID, AXIS_OUT_TLAST}, 0);
        check_vec("t7_start", {o_START, o_START_wstrobe, o_HARD_STOP_wstrobe}, 0);
        check_vec("t7_regs",  {o_FRAMES_SENT, o_ERROR}, 0);
        resetn = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
